// File: rtl/z_multdiv_ctrl.sv
// Issue/stall/writeback sequencer for the shared multi-cycle multiply/divide unit.
// Optional hang guard: define Z_MULTDIV_TIMEOUT_EN to force DONE with an exception after MAX_CYCLES.
module z_multdiv_ctrl #(
   parameter logic [4:0]  OP_MULT    = 5'b00110,
   parameter logic [4:0]  OP_DIV     = 5'b00111,
   parameter int unsigned MAX_CYCLES = 40,
   parameter int unsigned CNT_W      = 6
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic             is_ALU_op,
   input  logic [4:0]       ALU_op,
   input  logic [4:0]       dest_in,
   input  logic             flush,
   input  logic             unit_ready,
   input  logic             unit_exception,
   output logic             ctrl_MULT,
   output logic             ctrl_DIV,
   output logic             stall,
   output logic             busy,
   output logic             result_valid,
   output logic             result_exc,
   output logic [4:0]       dest_out,
   output logic [CNT_W-1:0] cycle_cnt
);

`ifdef Z_MULTDIV_TIMEOUT_EN
   localparam bit TIMEOUT_EN = 1'b1;
`else
   localparam bit TIMEOUT_EN = 1'b0;
`endif

   typedef enum logic [1:0] {StIdle, StStart, StRun, StDone} state_e;

   state_e           state_q;
   logic             kind_mult_q;
   logic [4:0]       dest_q;
   logic             exc_q;
   logic [CNT_W-1:0] cnt_q;

   logic issue;
   logic accept;
   logic cnt_max;
   logic timeout;

   assign issue   = is_ALU_op & ((ALU_op == OP_MULT) | (ALU_op == OP_DIV));
   assign accept  = ((state_q == StIdle) | (state_q == StDone)) & issue & ~flush;
   assign cnt_max = &cnt_q;
   // Constant-false when the guard is compiled out, so the compare folds away.
   assign timeout = TIMEOUT_EN && (cnt_q == CNT_W'(MAX_CYCLES - 1));

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q     <= StIdle;
         kind_mult_q <= 1'b0;
         dest_q      <= '0;
         exc_q       <= 1'b0;
         cnt_q       <= '0;
      end else begin
         unique case (state_q)
            StIdle, StDone: begin
               if (accept) begin
                  state_q     <= StStart;
                  dest_q      <= dest_in;
                  kind_mult_q <= (ALU_op == OP_MULT);
               end else begin
                  state_q <= StIdle;
               end
            end
            StStart: begin
               cnt_q   <= '0;
               state_q <= flush ? StIdle : StRun;
            end
            StRun: begin
               if (flush) begin
                  state_q <= StIdle;
               end else begin
                  if (!cnt_max) cnt_q <= cnt_q + 1'b1;
                  // A real ready on the timeout cycle takes precedence.
                  if (unit_ready) begin
                     state_q <= StDone;
                     exc_q   <= unit_exception;
                  end else if (timeout) begin
                     state_q <= StDone;
                     exc_q   <= 1'b1;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign busy         = (state_q == StStart) | (state_q == StRun);
   assign ctrl_MULT    = (state_q == StStart) & kind_mult_q & ~flush;
   assign ctrl_DIV     = (state_q == StStart) & ~kind_mult_q & ~flush;
   assign result_valid = (state_q == StDone);
   assign result_exc   = (state_q == StDone) & exc_q;
   assign dest_out     = dest_q;
   assign cycle_cnt    = cnt_q;
   // Gate with clrn so a pending issue cannot raise stall while reset is held.
   assign stall        = clrn & (accept | busy);

endmodule

// File: tb/tb_z_multdiv_ctrl.sv
// Directed self-checking bench for z_multdiv_ctrl.
module tb_z_multdiv_ctrl;
   logic       clk = 1'b0;
   logic       clrn = 1'b0;
   logic       is_ALU_op = 1'b0;
   logic [4:0] ALU_op = '0;
   logic [4:0] dest_in = '0;
   logic       flush = 1'b0;
   logic       unit_ready = 1'b0;
   logic       unit_exception = 1'b0;
   logic       ctrl_MULT, ctrl_DIV, stall, busy, result_valid, result_exc;
   logic [4:0] dest_out;
   logic [5:0] cycle_cnt;
   logic [16:0] outs;

   int n_tests = 0;
   int n_fail  = 0;

   z_multdiv_ctrl dut (
      .clk(clk), .clrn(clrn), .is_ALU_op(is_ALU_op), .ALU_op(ALU_op), .dest_in(dest_in),
      .flush(flush), .unit_ready(unit_ready), .unit_exception(unit_exception),
      .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV), .stall(stall), .busy(busy),
      .result_valid(result_valid), .result_exc(result_exc), .dest_out(dest_out),
      .cycle_cnt(cycle_cnt)
   );

   assign outs = {ctrl_MULT, ctrl_DIV, stall, busy, result_valid, result_exc, dest_out, cycle_cnt};

   always #5 clk = ~clk;

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #2;
   endtask

   task automatic idle_inputs;
      is_ALU_op = 1'b0; ALU_op = '0; dest_in = '0; flush = 1'b0;
      unit_ready = 1'b0; unit_exception = 1'b0;
   endtask

   task automatic test_reset;
      clrn = 1'b0; is_ALU_op = 1'b1; ALU_op = 5'd6;
      #3;
      n_tests++;
      if (outs !== 17'd0) begin
         n_fail++; $display("FAIL reset_outs: got %h want 0", outs);
      end
      idle_inputs();
      next_cycle();
      clrn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         next_cycle(); settle();
         n_tests++;
         if (outs !== 17'd0) begin
            n_fail++; $display("FAIL reset_idle%0d: got %h want 0", i, outs);
         end
      end
   endtask

   task automatic test_mult;
      next_cycle(); is_ALU_op = 1'b1; ALU_op = 5'd6; dest_in = 5'd7; settle();
      n_tests++;
      if ({stall, busy, ctrl_MULT, ctrl_DIV} !== 4'b1000) begin
         n_fail++; $display("FAIL mult_issue: got %b want 1000", {stall, busy, ctrl_MULT, ctrl_DIV});
      end
      next_cycle(); idle_inputs(); settle();
      n_tests++;
      if ({stall, busy, ctrl_MULT, ctrl_DIV} !== 4'b1110) begin
         n_fail++; $display("FAIL mult_start: got %b want 1110", {stall, busy, ctrl_MULT, ctrl_DIV});
      end
      for (int k = 2; k <= 33; k++) begin
         next_cycle(); unit_ready = (k == 33); settle();
         n_tests++;
         if ({stall, busy, ctrl_MULT, ctrl_DIV, result_valid} !== 5'b11000) begin
            n_fail++;
            $display("FAIL mult_run cyc%0d: got %b want 11000", k,
                     {stall, busy, ctrl_MULT, ctrl_DIV, result_valid});
         end
      end
      next_cycle(); unit_ready = 1'b0; settle();
      n_tests++;
      if ({result_valid, result_exc, stall, busy, dest_out, cycle_cnt} !== {4'b1000, 5'd7, 6'd32})
      begin
         n_fail++;
         $display("FAIL mult_done: got rv/exc/stall/busy=%b dest=%0d cnt=%0d want 1000 7 32",
                  {result_valid, result_exc, stall, busy}, dest_out, cycle_cnt);
      end
      next_cycle(); settle();
      n_tests++;
      if (result_valid !== 1'b0) begin
         n_fail++; $display("FAIL mult_rv_one_cycle: got %b want 0", result_valid);
      end
   endtask

   task automatic test_div_by_zero;
      next_cycle(); is_ALU_op = 1'b1; ALU_op = 5'd7; dest_in = 5'd3; settle();
      next_cycle(); idle_inputs(); settle();
      n_tests++;
      if ({ctrl_MULT, ctrl_DIV} !== 2'b01) begin
         n_fail++; $display("FAIL div_start: got %b want 01", {ctrl_MULT, ctrl_DIV});
      end
      for (int k = 2; k <= 5; k++) begin
         next_cycle();
         // A would-be MULT held on the bus while running must be ignored.
         is_ALU_op = (k < 5); ALU_op = 5'd6; dest_in = 5'd31;
         unit_ready = (k == 5); unit_exception = (k == 5);
         settle();
         n_tests++;
         if ({stall, busy, ctrl_MULT, result_valid} !== 4'b1100) begin
            n_fail++;
            $display("FAIL div_run cyc%0d: got %b want 1100", k,
                     {stall, busy, ctrl_MULT, result_valid});
         end
      end
      next_cycle(); idle_inputs(); settle();
      n_tests++;
      if ({result_valid, result_exc, dest_out, cycle_cnt} !== {2'b11, 5'd3, 6'd4}) begin
         n_fail++;
         $display("FAIL div_done: got rv/exc=%b dest=%0d cnt=%0d want 11 3 4",
                  {result_valid, result_exc}, dest_out, cycle_cnt);
      end
      next_cycle(); settle();
      n_tests++;
      if ({result_valid, result_exc, busy} !== 3'b000) begin
         n_fail++; $display("FAIL div_after: got %b want 000", {result_valid, result_exc, busy});
      end
   endtask

   task automatic test_non_muldiv;
      logic [5:0] vec [5];
      vec[0] = {1'b1, 5'd0}; vec[1] = {1'b1, 5'd5}; vec[2] = {1'b1, 5'd8};
      vec[3] = {1'b1, 5'd14}; vec[4] = {1'b0, 5'd6};
      for (int i = 0; i < 5; i++) begin
         next_cycle(); is_ALU_op = vec[i][5]; ALU_op = vec[i][4:0]; dest_in = 5'd9; settle();
         n_tests++;
         if (stall !== 1'b0) begin
            n_fail++; $display("FAIL nonop_stall%0d: got %b want 0", i, stall);
         end
         next_cycle(); idle_inputs(); settle();
         n_tests++;
         if ({busy, ctrl_MULT, ctrl_DIV, result_valid} !== 4'b0000) begin
            n_fail++;
            $display("FAIL nonop_state%0d: got %b want 0000", i,
                     {busy, ctrl_MULT, ctrl_DIV, result_valid});
         end
      end
   endtask

   task automatic test_back_to_back;
      next_cycle(); is_ALU_op = 1'b1; ALU_op = 5'd6; dest_in = 5'd9; settle();
      next_cycle(); idle_inputs(); settle();
      next_cycle(); settle();
      next_cycle(); unit_ready = 1'b1; settle();
      next_cycle(); unit_ready = 1'b0; is_ALU_op = 1'b1; ALU_op = 5'd6; dest_in = 5'd12; settle();
      n_tests++;
      if ({result_valid, stall, ctrl_MULT, dest_out, cycle_cnt} !== {3'b110, 5'd9, 6'd2}) begin
         n_fail++;
         $display("FAIL b2b_done_issue: got rv/stall/mult=%b dest=%0d cnt=%0d want 110 9 2",
                  {result_valid, stall, ctrl_MULT}, dest_out, cycle_cnt);
      end
      // Ready during START must be ignored.
      next_cycle(); idle_inputs(); unit_ready = 1'b1; settle();
      n_tests++;
      if ({ctrl_MULT, busy, stall, result_valid} !== 4'b1110) begin
         n_fail++;
         $display("FAIL b2b_start: got %b want 1110", {ctrl_MULT, busy, stall, result_valid});
      end
      next_cycle(); unit_ready = 1'b1; settle();
      n_tests++;
      if ({busy, result_valid, ctrl_MULT} !== 3'b100) begin
         n_fail++; $display("FAIL b2b_run: got %b want 100", {busy, result_valid, ctrl_MULT});
      end
      next_cycle(); unit_ready = 1'b0; settle();
      n_tests++;
      if ({result_valid, dest_out, cycle_cnt} !== {1'b1, 5'd12, 6'd1}) begin
         n_fail++;
         $display("FAIL b2b_done2: got rv=%b dest=%0d cnt=%0d want 1 12 1",
                  result_valid, dest_out, cycle_cnt);
      end
   endtask

   task automatic test_flush;
      // Flush in RUN, then a late ready for the killed op.
      next_cycle(); is_ALU_op = 1'b1; ALU_op = 5'd7; dest_in = 5'd5; settle();
      next_cycle(); idle_inputs(); settle();
      for (int k = 2; k <= 11; k++) begin
         next_cycle(); flush = (k == 11); settle();
      end
      n_tests++;
      if ({stall, busy} !== 2'b11) begin
         n_fail++; $display("FAIL flush_run_cycle: got %b want 11", {stall, busy});
      end
      next_cycle(); flush = 1'b0; settle();
      n_tests++;
      if ({stall, busy, result_valid} !== 3'b000) begin
         n_fail++; $display("FAIL flush_run_idle: got %b want 000", {stall, busy, result_valid});
      end
      next_cycle(); unit_ready = 1'b1; unit_exception = 1'b1; settle();
      next_cycle(); idle_inputs(); settle();
      n_tests++;
      if ({result_valid, busy, result_exc} !== 3'b000) begin
         n_fail++;
         $display("FAIL flush_late_ready: got %b want 000", {result_valid, busy, result_exc});
      end
      // Flush in START suppresses the pulse.
      next_cycle(); is_ALU_op = 1'b1; ALU_op = 5'd6; dest_in = 5'd1; settle();
      next_cycle(); idle_inputs(); flush = 1'b1; settle();
      n_tests++;
      if ({ctrl_MULT, ctrl_DIV, stall} !== 3'b001) begin
         n_fail++; $display("FAIL flush_start: got %b want 001", {ctrl_MULT, ctrl_DIV, stall});
      end
      next_cycle(); flush = 1'b0; settle();
      n_tests++;
      if ({busy, stall} !== 2'b00) begin
         n_fail++; $display("FAIL flush_start_idle: got %b want 00", {busy, stall});
      end
      // Flush on the issue cycle blocks acceptance.
      next_cycle(); is_ALU_op = 1'b1; ALU_op = 5'd7; flush = 1'b1; settle();
      n_tests++;
      if (stall !== 1'b0) begin
         n_fail++; $display("FAIL flush_issue_stall: got %b want 0", stall);
      end
      next_cycle(); idle_inputs(); settle();
      n_tests++;
      if ({busy, ctrl_MULT, ctrl_DIV} !== 3'b000) begin
         n_fail++; $display("FAIL flush_issue_state: got %b want 000", {busy, ctrl_MULT, ctrl_DIV});
      end
      // Flush in DONE keeps the strobe but blocks a new issue.
      next_cycle(); is_ALU_op = 1'b1; ALU_op = 5'd7; dest_in = 5'd4; settle();
      next_cycle(); idle_inputs(); settle();
      next_cycle(); unit_ready = 1'b1; settle();
      next_cycle(); unit_ready = 1'b0; is_ALU_op = 1'b1; ALU_op = 5'd6; flush = 1'b1; settle();
      n_tests++;
      if ({result_valid, stall, dest_out} !== {2'b10, 5'd4}) begin
         n_fail++;
         $display("FAIL flush_done: got rv/stall=%b dest=%0d want 10 4",
                  {result_valid, stall}, dest_out);
      end
      next_cycle(); idle_inputs(); settle();
      n_tests++;
      if ({busy, ctrl_MULT, result_valid} !== 3'b000) begin
         n_fail++;
         $display("FAIL flush_done_next: got %b want 000", {busy, ctrl_MULT, result_valid});
      end
   endtask

   task automatic test_reset_mid_op;
      next_cycle(); is_ALU_op = 1'b1; ALU_op = 5'd6; dest_in = 5'd17; settle();
      next_cycle(); idle_inputs(); settle();
      for (int k = 2; k <= 5; k++) begin
         next_cycle(); settle();
      end
      is_ALU_op = 1'b1; ALU_op = 5'd6;
      #1 clrn = 1'b0;
      #1;
      n_tests++;
      if (outs !== 17'd0) begin
         n_fail++; $display("FAIL reset_mid_op: got %h want 0", outs);
      end
      idle_inputs();
      next_cycle(); clrn = 1'b1;
      next_cycle(); unit_ready = 1'b1; settle();
      next_cycle(); unit_ready = 1'b0; settle();
      n_tests++;
      if (outs !== 17'd0) begin
         n_fail++; $display("FAIL reset_mid_op_after: got %h want 0", outs);
      end
   endtask

`ifdef Z_MULTDIV_TIMEOUT_EN
   task automatic test_timeout;
      next_cycle(); is_ALU_op = 1'b1; ALU_op = 5'd7; dest_in = 5'd21; settle();
      next_cycle(); idle_inputs(); settle();
      for (int k = 2; k <= 41; k++) begin
         next_cycle(); settle();
         n_tests++;
         if ({stall, result_valid, cycle_cnt} !== {2'b10, 6'(k - 2)}) begin
            n_fail++;
            $display("FAIL timeout_run cyc%0d: got stall/rv=%b cnt=%0d want 10 %0d", k,
                     {stall, result_valid}, cycle_cnt, k - 2);
         end
      end
      next_cycle(); settle();
      n_tests++;
      if ({result_valid, result_exc, busy, dest_out, cycle_cnt} !== {3'b110, 5'd21, 6'd40}) begin
         n_fail++;
         $display("FAIL timeout_done: got rv/exc/busy=%b dest=%0d cnt=%0d want 110 21 40",
                  {result_valid, result_exc, busy}, dest_out, cycle_cnt);
      end
   endtask
`else
   task automatic test_no_timeout;
      int exp_cnt;
      next_cycle(); is_ALU_op = 1'b1; ALU_op = 5'd6; dest_in = 5'd2; settle();
      next_cycle(); idle_inputs(); settle();
      for (int k = 2; k <= 72; k++) begin
         next_cycle(); unit_ready = (k == 72); settle();
         exp_cnt = (k - 2 > 63) ? 63 : k - 2;
         n_tests++;
         if ({stall, result_valid, cycle_cnt} !== {2'b10, 6'(exp_cnt)}) begin
            n_fail++;
            $display("FAIL hold_run cyc%0d: got stall/rv=%b cnt=%0d want 10 %0d", k,
                     {stall, result_valid}, cycle_cnt, exp_cnt);
         end
      end
      next_cycle(); unit_ready = 1'b0; settle();
      n_tests++;
      if ({result_valid, result_exc, dest_out, cycle_cnt} !== {2'b10, 5'd2, 6'd63}) begin
         n_fail++;
         $display("FAIL hold_done: got rv/exc=%b dest=%0d cnt=%0d want 10 2 63",
                  {result_valid, result_exc}, dest_out, cycle_cnt);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_mult();
      test_div_by_zero();
      test_non_muldiv();
      test_back_to_back();
      test_flush();
      test_reset_mid_op();
`ifdef Z_MULTDIV_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
